clk_divider_prog: RTL and testbench
===================================

# clk_divider_prog

Runtime-programmable clock divider: the next generation of the fixed-ratio divider. Produces a registered divided clock `clk_out` from `clk_in`, with a WIDTH-bit divisor loadable at run time through a load handshake, applied glitch-free only at period boundaries. It supports both even and odd ratios, a freeze enable, and an error flag for illegal divisors. It sits beside the system clock source and feeds slow-rate logic such as LED blinkers, sample strobes, and low-speed serial bit clocks.

## Interface
- `WIDTH`, 16: divisor width in bits.
- `DEFAULT_DIV`, 10: divisor loaded by reset; must be ≥2 and <2^WIDTH.

- `clk_in`  in  1  input clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  count enable; 0 freezes the counter and `clk_out`.
- `div_in`  in  WIDTH  new divisor value.
- `div_load`  in  1  one-cycle request to load `div_in`.
- `div_ack`  out  1  one-cycle pulse when a pending divisor takes effect.
- `div_cur`  out  WIDTH  divisor currently in force.
- `div_err`  out  1  sticky; set by a load with `div_in` < 2.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse at each `clk_out` rising edge (only with `CLK_DIV_TICK_EN`).

## Operation
- State: `cnt` (WIDTH bits), `cur_div`, `pend_div`, `pend_vld`, `clk_out`, `div_err`.
- Reset (`rst`=1 at an edge) sets:
  - `cnt`=0, `cur_div`=DEFAULT_DIV, `pend_vld`=0.
  - `clk_out`=0, `div_ack`=0, `div_err`=0, `tick`=0.
  - `rst` has priority over every other input. A reset mid-period drops the pending load.
- Counting (`en`=1): `cnt` advances 0 → `cur_div`-1, then wraps to 0.
- High time is H = `cur_div`>>1:
  - Each edge with `en`=1: `clk_out` <= (`cnt` < H).
  - Even D: 50 % duty. Odd D: high floor(D/2), low ceil(D/2).
- Freeze (`en`=0): `cnt`, `clk_out` and `cur_div` hold. Loads are still accepted and made pending.
- Load:
  - `div_load`=1 with `div_in` ≥2: `pend_div` <= `div_in`, `pend_vld` <= 1.
  - A second load before application overwrites the first (last writer wins).
  - `div_load`=1 with `div_in` <2: rejected. `div_err` <= 1, pending state unchanged.
  - `div_err` clears only on `rst`.
- Boundary (`en`=1 and `cnt`=`cur_div`-1):
  - `cnt` <= 0.
  - If `pend_vld` is set: `cur_div` <= `pend_div`, `pend_vld` <= 0, `div_ack` pulses for 1 cycle.
- Simultaneous load and boundary: the pending value as registered before that edge is applied. The new `div_in` becomes pending for the following boundary.
- `div_cur` = `cur_div` (registered).

## Timing
- First edge after `rst` falls with `en`=1: `clk_out` goes high.
- `clk_out` lags `cnt` by one cycle. High cycles are 1..H after the wrap, then low until the next wrap.
- Period is exactly `cur_div` cycles of `clk_in` while `en`=1. Each cycle with `en`=0 stretches it by one cycle.
- A new divisor affects the period that starts after the boundary edge. `div_ack` and the new `div_cur` appear at that same edge.
- `clk_out` is driven from a flop only; it never glitches on a divisor change.

## Configuration
- `CLK_DIV_TICK_EN` defined:
  - `tick` port present.
  - `tick` <= `en` && (`cnt`==0), so it is high in the same cycle `clk_out` first reads 1.
- Not defined: `tick` port and its flop are absent. All other behaviour is identical.

## Structure
- Package `clk_div_pkg` holds:
  - `CLK_DIV_MIN` = 2.
  - Default `WIDTH` and `DEFAULT_DIV` constants.
  - The `div_t` typedef (logic [WIDTH-1:0]) for the default width.
- Sub-module `clk_div_core` contains the counter, wrap detect and `clk_out`/`tick` flops, driven by `cur_div` and `en`.
- Top-level `clk_divider_prog` contains the load/pending/ack/error logic and instantiates `clk_div_core`.

## Test plan
All scenarios use DEFAULT_DIV=10 and a 1 kHz `clk_in`.
- Release `rst` with `en`=1 → `clk_out` high 5 cycles, low 5, period 10 (100 Hz); `div_cur`=10.
- Load 4 when `cnt`=3 → current period still 10 cycles; `div_ack` pulses at the wrap; then period 4 (high 2, low 2); `div_cur`=4.
- Load 5 → after the boundary, high 2, low 3, period 5; `tick` (if enabled) pulses once per period on the `clk_out` rise.
- Load 1, then load 0 → `div_err`=1 and stays set; period stays 10; no `div_ack`.
- `en`=0 for 3 cycles mid-high → `clk_out` held at 1; that period measures 13 cycles; the next period is 10.
- Load 6, then assert `rst` before the boundary → next edge `clk_out`=0, `div_cur`=10, `div_err`=0; after release the period is 10, not 6.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
// The optional tick output is enabled with CLK_DIV_TICK_EN.
package clk_div_pkg;

    localparam int unsigned CLK_DIV_MIN     = 2;
    localparam int unsigned CLK_DIV_WIDTH   = 16;
    localparam int unsigned CLK_DIV_DEFAULT = 10;

    typedef logic [CLK_DIV_WIDTH-1:0] div_t;

endpackage

// File: rtl/clk_div_core.sv
// Counter, wrap detect and registered divided clock for clk_divider_prog.
// The tick flop exists only when CLK_DIV_TICK_EN is defined.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH = CLK_DIV_WIDTH
)
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_div,
    output logic             o_clk,
    output logic             o_wrap
`ifdef CLK_DIV_TICK_EN
    ,
    output logic             o_tick
`endif
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_clk;
    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_high;

    assign w_last = i_div - WIDTH'(1);
    assign w_high = i_div >> 1;
    assign o_wrap = i_en && (r_cnt == w_last);
    assign o_clk  = r_clk;

    // High while the count is still below half the divisor; odd ratios get the short half high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
        end else if (i_en) begin
            r_clk <= (r_cnt < w_high);
            r_cnt <= o_wrap ? '0 : r_cnt + WIDTH'(1);
        end
    end

`ifdef CLK_DIV_TICK_EN
    logic r_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= i_en && (r_cnt == '0);
        end
    end

    assign o_tick = r_tick;
`endif

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider: divisor load handshake, pending/ack and sticky error.
// Define CLK_DIV_TICK_EN to add the tick output pulsing on each clk_out rise.
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = CLK_DIV_WIDTH,
    parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT
)
(
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic [WIDTH-1:0] div_cur,
    output logic             div_err,
    output logic             clk_out
`ifdef CLK_DIV_TICK_EN
    ,
    output logic             tick
`endif
);

    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_pend;
    logic             r_pvld;
    logic             r_ack;
    logic             r_err;
    logic             w_wrap;
    logic             w_load_ok;
    logic             w_load_bad;

    assign w_load_ok  = div_load && (div_in >= WIDTH'(CLK_DIV_MIN));
    assign w_load_bad = div_load && (div_in <  WIDTH'(CLK_DIV_MIN));

    // A load coinciding with a boundary applies the older pending value and queues the new one.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cur  <= WIDTH'(DEFAULT_DIV);
            r_pend <= WIDTH'(DEFAULT_DIV);
            r_pvld <= 1'b0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_wrap && r_pvld) begin
                r_cur  <= r_pend;
                r_pvld <= 1'b0;
                r_ack  <= 1'b1;
            end
            if (w_load_ok) begin
                r_pend <= div_in;
                r_pvld <= 1'b1;
            end
            if (w_load_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign div_ack = r_ack;
    assign div_cur = r_cur;
    assign div_err = r_err;

    clk_div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_clk  (clk_in),
        .i_rst  (rst),
        .i_en   (en),
        .i_div  (r_cur),
        .o_clk  (clk_out),
        .o_wrap (w_wrap)
`ifdef CLK_DIV_TICK_EN
        ,
        .o_tick (tick)
`endif
    );

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: directed scenarios plus randomized traffic
// compared cycle by cycle against a period-position reference model.
module tb_clk_divider_prog;

    localparam int unsigned W   = 16;
    localparam int unsigned DEF = 10;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         div_load = 1'b0;
    logic         div_ack;
    logic [W-1:0] div_cur;
    logic         div_err;
    logic         clk_out;
`ifdef CLK_DIV_TICK_EN
    logic         tick;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the current output period, counted in enabled edges.
    int unsigned m_pos  = 0;
    int unsigned m_div  = DEF;
    int unsigned m_pend = DEF;
    bit          m_pvld = 1'b0;
    bit          m_clk  = 1'b0;
    bit          m_ack  = 1'b0;
    bit          m_err  = 1'b0;
    bit          m_tick = 1'b0;

    logic prev_clk = 1'b0;
    bit   rose     = 1'b0;
    int   ack_cnt  = 0;

    always #5 clk_in = ~clk_in;

    clk_divider_prog #(
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_cur  (div_cur),
        .div_err  (div_err),
        .clk_out  (clk_out)
`ifdef CLK_DIV_TICK_EN
        ,
        .tick     (tick)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit boundary;
        boundary = 1'b0;
        if (rst) begin
            m_pos  = 0;
            m_div  = DEF;
            m_pvld = 1'b0;
            m_clk  = 1'b0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
            m_tick = 1'b0;
        end else begin
            m_ack  = 1'b0;
            m_tick = 1'b0;
            if (en) begin
                m_tick = (m_pos == 0);
                m_clk  = (m_pos < m_div / 2);
                m_pos  = m_pos + 1;
                if (m_pos == m_div) begin
                    m_pos    = 0;
                    boundary = 1'b1;
                end
            end
            if (boundary && m_pvld) begin
                m_div  = m_pend;
                m_pvld = 1'b0;
                m_ack  = 1'b1;
            end
            if (div_load) begin
                if (div_in >= 2) begin
                    m_pend = div_in;
                    m_pvld = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        model_edge();
        rose     = (prev_clk == 1'b0) && (clk_out == 1'b1);
        prev_clk = clk_out;
        if (div_ack === 1'b1) ack_cnt++;
        check_eq("clk_out", 32'(clk_out), 32'(m_clk));
        check_eq("div_ack", 32'(div_ack), 32'(m_ack));
        check_eq("div_cur", 32'(div_cur), m_div);
        check_eq("div_err", 32'(div_err), 32'(m_err));
`ifdef CLK_DIV_TICK_EN
        check_eq("tick", 32'(tick), 32'(m_tick));
`endif
    endtask

    task automatic wait_rise(input string tag);
        int n;
        bit timed_out;
        n = 0;
        timed_out = 1'b0;
        do begin
            step();
            n++;
        end while (!rose && n < 200);
        if (!rose) timed_out = 1'b1;
        check_eq({tag, "_rise_timeout"}, 32'(timed_out), 32'd0);
    endtask

    task automatic measure(input string tag, input int exp_hi, input int exp_lo);
        int hi;
        int lo;
        hi = 0;
        lo = 0;
        wait_rise(tag);
        while (clk_out === 1'b1 && hi < 200) begin
            hi++;
            step();
        end
        while (clk_out === 1'b0 && lo < 200) begin
            lo++;
            step();
        end
        check_eq({tag, "_high"}, 32'(hi), 32'(exp_hi));
        check_eq({tag, "_low"}, 32'(lo), 32'(exp_lo));
    endtask

    task automatic load(input int unsigned value);
        div_load = 1'b1;
        div_in   = W'(value);
        step();
        div_load = 1'b0;
        div_in   = '0;
    endtask

    initial begin
        int acks0;
        int len;

        // Reset state
        rst = 1'b1;
        en  = 1'b1;
        step();
        step();
        check_eq("rst_clk_out", 32'(clk_out), 32'd0);
        check_eq("rst_div_cur", 32'(div_cur), 32'd10);
        check_eq("rst_div_err", 32'(div_err), 32'd0);
        check_eq("rst_div_ack", 32'(div_ack), 32'd0);

        // First edge after release drives clk_out high
        rst = 1'b0;
        step();
        check_eq("first_edge_high", 32'(clk_out), 32'd1);
        measure("div10", 5, 5);

        // Freeze mid-high stretches one period by the frozen cycles
        wait_rise("freeze");
        len = 0;
        step();
        len++;
        en = 1'b0;
        repeat (3) begin
            step();
            len++;
            check_eq("freeze_hold", 32'(clk_out), 32'd1);
        end
        en = 1'b1;
        do begin
            step();
            len++;
        end while (!rose && len < 200);
        check_eq("freeze_period", 32'(len), 32'd13);
        measure("after_freeze", 5, 5);

        // Load 4 mid-period: one ack at the wrap, then period 4
        step();
        step();
        acks0 = ack_cnt;
        load(4);
        measure("div4", 2, 2);
        check_eq("div4_cur", 32'(div_cur), 32'd4);
        check_eq("div4_acks", 32'(ack_cnt - acks0), 32'd1);

        // Load 5: odd ratio, high 2 low 3
        acks0 = ack_cnt;
        load(5);
        measure("div5", 2, 3);
        check_eq("div5_cur", 32'(div_cur), 32'd5);
        check_eq("div5_acks", 32'(ack_cnt - acks0), 32'd1);

        // Illegal loads set the sticky error and never ack
        rst = 1'b1;
        step();
        rst = 1'b0;
        acks0 = ack_cnt;
        load(1);
        load(0);
        check_eq("err_set", 32'(div_err), 32'd1);
        measure("err_div10", 5, 5);
        measure("err_div10b", 5, 5);
        check_eq("err_sticky", 32'(div_err), 32'd1);
        check_eq("err_no_ack", 32'(ack_cnt - acks0), 32'd0);
        check_eq("err_cur", 32'(div_cur), 32'd10);

        // Reset before the boundary drops a pending load
        wait_rise("pre_rst");
        acks0 = ack_cnt;
        load(6);
        step();
        rst = 1'b1;
        step();
        check_eq("rstdrop_clk_out", 32'(clk_out), 32'd0);
        check_eq("rstdrop_div_cur", 32'(div_cur), 32'd10);
        check_eq("rstdrop_div_err", 32'(div_err), 32'd0);
        rst = 1'b0;
        measure("rstdrop_div10", 5, 5);
        measure("rstdrop_div10b", 5, 5);
        check_eq("rstdrop_no_ack", 32'(ack_cnt - acks0), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 7) != 0);
            div_load = ($urandom_range(0, 9) == 0);
            div_in   = W'($urandom_range(0, 12));
            step();
        end
        rst      = 1'b0;
        div_load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
